// File: rtl/fsm_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// fsm_ctrl_pkg
// Shared definitions for the seven-state x1/x2/x3 Moore controller and the
// passive input decoder that watches it.
//   - ST_A .. ST_G : state codes (ST_U is the unused code 011)
//   - expected_z() : Moore output expected for a given state
//   - decode()     : maps an observed (prev -> cur) transition back onto the
//                    input bits {x1,x2,x3} that must have caused it
// ---------------------------------------------------------------------------
package fsm_ctrl_pkg;

    localparam logic [2:0] ST_A = 3'b000;
    localparam logic [2:0] ST_B = 3'b001;
    localparam logic [2:0] ST_C = 3'b101;
    localparam logic [2:0] ST_D = 3'b010;
    localparam logic [2:0] ST_E = 3'b100;
    localparam logic [2:0] ST_F = 3'b110;
    localparam logic [2:0] ST_G = 3'b111;
    localparam logic [2:0] ST_U = 3'b011;

    // One recovered-input record as stored in the queue.
    typedef struct packed {
        logic [2:0] x;
        logic [2:0] mask;
    } rec_t;

    // Result of decoding one transition.
    typedef struct packed {
        logic       legal;
        logic       has_record;
        logic [2:0] x;
        logic [2:0] mask;
    } dec_t;

    function automatic logic [2:0] expected_z(input logic [2:0] y);
        case (y)
            ST_D:    return 3'b100;
            ST_E:    return 3'b010;
            ST_G:    return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    function automatic dec_t dec_rec(input logic [2:0] x, input logic [2:0] mask);
        dec_t d;
        d.legal      = 1'b1;
        d.has_record = 1'b1;
        d.x          = x;
        d.mask       = mask;
        return d;
    endfunction

    // Each state only looks at a subset of the inputs, so the mask says which
    // bits of x the transition actually pins down.
    function automatic dec_t decode(input logic [2:0] prev, input logic [2:0] cur);
        dec_t d;
        d = '0;  // anything not matched below is an illegal transition
        case (prev)
            ST_A: begin
                if (cur == ST_B)      d = dec_rec(3'b100, 3'b100);
                else if (cur == ST_C) d = dec_rec(3'b000, 3'b100);
            end
            ST_B: begin
                if (cur == ST_D)      d = dec_rec(3'b010, 3'b010);
                else if (cur == ST_A) d = dec_rec(3'b000, 3'b010);
            end
            ST_C: begin
                if (cur == ST_E)      d = dec_rec(3'b011, 3'b011);
                else if (cur == ST_A) d = dec_rec(3'b010, 3'b011);
                else if (cur == ST_F) d = dec_rec(3'b001, 3'b011);
                else if (cur == ST_G) d = dec_rec(3'b000, 3'b011);
            end
            default: begin
                // D, E, F, G and the undefined code fall back to A
                // unconditionally, so the step reveals nothing about x.
                if (cur == ST_A) d.legal = 1'b1;
            end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/fsm_dec_fifo.sv
// ---------------------------------------------------------------------------
// fsm_dec_fifo
// Circular queue of DEPTH records with occupancy count.
//   clk, reset      : clock, asynchronous active-high reset
//   push, push_data : offer a record this cycle
//   pop             : consumer takes the head this cycle (ignored when empty)
//   head_data       : head record, zero when empty
//   head_valid      : queue not empty
//   count           : occupancy, 0..DEPTH
//   overflow        : a push was dropped this cycle (full and no pop)
// ---------------------------------------------------------------------------
module fsm_dec_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 6,
    localparam int CNT_W = $clog2(DEPTH) + 1,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             head_valid,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        full       = (count == CNT_W'(DEPTH));
        head_valid = (count != '0);
        do_pop     = pop && head_valid;
        // A full queue still accepts a push when the head leaves the same
        // cycle; the write lands on the slot being vacated.
        do_push    = push && (!full || do_pop);
        overflow   = push && full && !do_pop;
        head_data  = head_valid ? mem[rd_ptr] : '0;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            // DEPTH is a power of two, so natural pointer wrap is modulo DEPTH.
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    // NOTE: storage is not reset; an entry is only read once the count says
    // it was written, and head_data is forced to zero while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fsm_input_decoder.sv
// ---------------------------------------------------------------------------
// fsm_input_decoder
// Passive monitor for the x1/x2/x3 Moore controller: watches (y, z), recovers
// the inputs that caused each transition and queues them for a consumer.
//   clk, reset            : clock, asynchronous active-high reset
//   in_valid              : one observed controller step this cycle
//   mon_reset             : controller was in reset for this step
//   y_in, z_in            : observed controller state and output
//   clear_err             : clears the sticky error flags (a new error wins)
//   out_valid/out_ready   : valid/ready handshake for the recovered records
//   out_x, out_mask       : recovered {x1,x2,x3} and which bits are known
//   count                 : queue occupancy
//   err_illegal/err_z/err_ovf : sticky error flags
//   illegal_pulse         : one-cycle strobe per illegal transition
// ---------------------------------------------------------------------------
module fsm_input_decoder
    import fsm_ctrl_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             mon_reset,
    input  logic [2:0]       y_in,
    input  logic [2:0]       z_in,
    input  logic             clear_err,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out_x,
    output logic [2:0]       out_mask,
    output logic [CNT_W-1:0] count,
    output logic             err_illegal,
    output logic             err_z,
    output logic             err_ovf,
    output logic             illegal_pulse
);

    logic [2:0] prev;
    logic       have_prev;
    dec_t       dec;
    logic       decode_en;
    logic       rec_push;
    logic       illegal_now;
    logic       z_bad;
    logic       fifo_ovf;
    rec_t       rec_in;
    rec_t       head;

    // NOTE: every combinational output gets a value on every path, so no
    // latches are inferred.
    always_comb begin
        dec         = decode(prev, y_in);
        // The first step after any reset only seeds the tracker.
        decode_en   = in_valid && !mon_reset && have_prev;
        rec_push    = decode_en && dec.has_record;
        illegal_now = decode_en && !dec.legal;
        z_bad       = in_valid && (z_in != expected_z(y_in));
        rec_in.x    = dec.x;
        rec_in.mask = dec.mask;
    end

    // Tracker: always follows the observed state, which also resynchronises
    // it after an illegal transition.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev      <= ST_A;
            have_prev <= 1'b0;
        end else if (in_valid) begin
            prev      <= y_in;
            have_prev <= 1'b1;
        end
    end

    // Sticky flags: a new error in the same cycle as clear_err keeps the flag set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_illegal   <= 1'b0;
            err_z         <= 1'b0;
            err_ovf       <= 1'b0;
            illegal_pulse <= 1'b0;
        end else begin
            illegal_pulse <= illegal_now;
            if (illegal_now)    err_illegal <= 1'b1;
            else if (clear_err) err_illegal <= 1'b0;
            if (z_bad)          err_z <= 1'b1;
            else if (clear_err) err_z <= 1'b0;
            if (fifo_ovf)       err_ovf <= 1'b1;
            else if (clear_err) err_ovf <= 1'b0;
        end
    end

    fsm_dec_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(rec_t))
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (rec_push),
        .push_data  (rec_in),
        .pop        (out_valid && out_ready),
        .head_data  (head),
        .head_valid (out_valid),
        .count      (count),
        .overflow   (fifo_ovf)
    );

    assign out_x    = head.x;
    assign out_mask = head.mask;

endmodule
